// File: rtl/rs232_uart.sv
// rs232_uart -- full-duplex 8N1 UART core.
//
// Transmitter serialises DIN onto TX whenever it is idle and DRL is high,
// pulsing LOAD on the edge that captures DIN. Receiver synchronises RX,
// deserialises one character and pulses STORE when DOUT is updated.
// Both halves share only CLK and INIT, so TX may be looped back onto RX.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (minimum 4)
//   DATA_BITS     data bits per character (fixed at 8)
//
// Ports:
//   CLK    in   system clock, rising edge
//   INIT   in   asynchronous active-high reset
//   DRL    in   data-ready level from the frame interface
//   DIN    in   byte to transmit, captured on the LOAD edge
//   LOAD   out  one-cycle pulse, DIN captured
//   TX     out  serial output, idle high
//   RX     in   serial input, asynchronous to CLK
//   STORE  out  one-cycle pulse, new byte on DOUT
//   DOUT   out  last received byte
//
// Optional feature macro: RS232_PARITY_EN
//   When defined, an even parity bit is sent/checked between data bit 7 and
//   the stop bit. A parity mismatch suppresses STORE but the stop bit is still
//   consumed. When undefined the core is plain 8N1.

module rs232_uart #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLK,
   input  logic                 INIT,
   input  logic                 DRL,
   input  logic [DATA_BITS-1:0] DIN,
   output logic                 LOAD,
   output logic                 TX,
   input  logic                 RX,
   output logic                 STORE,
   output logic [DATA_BITS-1:0] DOUT
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
   } rx_state_t;

   tx_state_t            tx_state;
   logic [CNT_W-1:0]     tx_cnt;
   logic [BIT_W-1:0]     tx_bit;
   logic [DATA_BITS-1:0] tx_shift;

   rx_state_t            rx_state;
   logic [CNT_W-1:0]     rx_cnt;
   logic [BIT_W-1:0]     rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_meta;
   logic                 rx_sync;

`ifdef RS232_PARITY_EN
   logic                 tx_par;
   logic                 rx_par_err;
`endif

   // Transmitter: TX is a registered output driven one state ahead, so each
   // bit level appears on the edge that enters its bit period. The shift
   // register is loaded on the LOAD edge, so later DIN changes are ignored.
   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         LOAD     <= 1'b0;
         TX       <= 1'b1;
`ifdef RS232_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         LOAD <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (DRL) begin
                  tx_shift <= DIN;
                  LOAD     <= 1'b1;
                  TX       <= 1'b0;
                  tx_cnt   <= '0;
                  tx_state <= TX_START;
`ifdef RS232_PARITY_EN
                  tx_par   <= ^DIN;
`endif
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  TX       <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == DATA_LAST) begin
`ifdef RS232_PARITY_EN
                     TX       <= tx_par;
                     tx_state <= TX_PARITY;
`else
                     TX       <= 1'b1;
                     tx_state <= TX_STOP;
`endif
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     TX       <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
`ifdef RS232_PARITY_EN
            TX_PARITY: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  TX       <= 1'b1;
                  tx_state <= TX_STOP;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
`endif
            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               TX       <= 1'b1;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   // Two-flop synchroniser; resets to the idle (high) line level so a reset
   // never looks like a start bit.
   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
      end
   end

   // Receiver: the start bit is confirmed at its half-bit point, after which
   // every sample falls a whole bit period later, i.e. at each bit centre.
   // Returning to idle at the stop-bit centre lets the next start bit be
   // caught with no extra idle time.
   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         STORE      <= 1'b0;
         DOUT       <= '0;
`ifdef RS232_PARITY_EN
         rx_par_err <= 1'b0;
`endif
      end else begin
         STORE <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                  if (rx_bit == DATA_LAST) begin
`ifdef RS232_PARITY_EN
                     rx_state <= RX_PARITY;
`else
                     rx_state <= RX_STOP;
`endif
                  end else begin
                     rx_bit <= rx_bit + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
`ifdef RS232_PARITY_EN
            RX_PARITY: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt     <= '0;
                  rx_par_err <= rx_sync ^ (^rx_shift);
                  rx_state   <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_sync) begin
`ifdef RS232_PARITY_EN
                     if (!rx_par_err) begin
                        DOUT  <= rx_shift;
                        STORE <= 1'b1;
                     end
`else
                     DOUT  <= rx_shift;
                     STORE <= 1'b1;
`endif
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_BREAK;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            // Framing error: wait for the line to return high so a held-low
            // break is not mistaken for a stream of start bits.
            RX_BREAK: begin
               if (rx_sync) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: begin
               rx_state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_uart.sv
// tb_rs232_uart -- self-checking bench for rs232_uart at 8 clocks per bit.
// Expected TX bytes and expected received bytes are queued when stimulus is
// driven; background monitors decode TX frames and STORE pulses and pop the
// queues to compare.

module tb_rs232_uart;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       init = 1'b1;
   logic       drl = 1'b0;
   logic [7:0] din = 8'h00;
   logic       rx_drive = 1'b1;
   logic       loopback = 1'b0;
   logic       load;
   logic       tx;
   logic       store;
   logic [7:0] dout;
   logic       rx_line;

   assign rx_line = loopback ? tx : rx_drive;

   rs232_uart #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8)
   ) dut (
      .CLK  (clk),
      .INIT (init),
      .DRL  (drl),
      .DIN  (din),
      .LOAD (load),
      .TX   (tx),
      .RX   (rx_line),
      .STORE(store),
      .DOUT (dout)
   );

   always #5 clk = ~clk;

   int         check_count = 0;
   int         fail_count  = 0;
   int         store_count = 0;
   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];
   logic [7:0] tx_send[$];
   logic       tx_mon_on = 1'b0;
   logic [7:0] mon_byte;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one 8N1 frame on RX, each bit CPB clocks; caller is at a negedge.
   task automatic driveRxFrame(input logic [7:0] data, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx_drive = frame[b];
         repeat (CPB) @(negedge clk);
      end
   endtask

   // Sends every byte in tx_send through the DRL/LOAD handshake, presenting
   // the next byte on each LOAD and queueing the expected results.
   task automatic applyStimulus();
      int gap;
      @(negedge clk);
      din = tx_send[0];
      drl = 1'b1;
      for (int i = 0; i < tx_send.size(); i++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (load !== 1'b1 && gap < 300);
         checkOutput($sformatf("tx_load_seen_%0d", i), int'(load === 1'b1), 1);
         if (load !== 1'b1) break;
         if (i > 0) checkOutput($sformatf("tx_load_gap_%0d", i), gap, CPB * 10 + 1);
         tx_exp_q.push_back(tx_send[i]);
         if (loopback) rx_exp_q.push_back(tx_send[i]);
         if (i + 1 < tx_send.size()) begin
            din = tx_send[i+1];
         end else begin
            drl = 1'b0;
            din = ~tx_send[i];
         end
      end
      drl = 1'b0;
   endtask

   // Waits (bounded) for all queued expectations to be consumed.
   task automatic waitDrain();
      int n;
      n = 0;
      while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tx_queue_drained", tx_exp_q.size(), 0);
      checkOutput("rx_queue_drained", rx_exp_q.size(), 0);
      repeat (CPB) @(negedge clk);
   endtask

   // STORE monitor: every pulse must match the oldest expected byte.
   initial begin
      forever begin
         @(negedge clk);
         if (store === 1'b1) begin
            store_count++;
            checkOutput("rx_store_expected", int'(rx_exp_q.size() != 0), 1);
            if (rx_exp_q.size() != 0) checkOutput("rx_dout", int'(dout), int'(rx_exp_q.pop_front()));
         end
      end
   end

   // TX frame monitor: detects the start bit and samples near bit centres.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_mon_on && tx === 1'b0) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            checkOutput("tx_start_bit", int'(tx), 0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_byte[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            checkOutput("tx_stop_bit", int'(tx), 1);
            checkOutput("tx_frame_expected", int'(tx_exp_q.size() != 0), 1);
            if (tx_exp_q.size() != 0) checkOutput("tx_byte", int'(mon_byte), int'(tx_exp_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired checks=%0d", check_count);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int         base;
      int         load_hi;
      int         tx_low_seen;
      logic [79:0] wave;
      logic [9:0] frame;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", int'(tx), 1);
      checkOutput("reset_load", int'(load), 0);
      checkOutput("reset_store", int'(store), 0);
      checkOutput("reset_dout", int'(dout), 0);
      init = 1'b0;
      repeat (4) @(negedge clk);

      // RX single byte
      base = store_count;
      rx_exp_q.push_back(8'h3C);
      driveRxFrame(8'h3C, 1'b1);
      checkOutput("rx_store_by_stop_end", store_count - base, 1);
      repeat (5 * CPB) @(negedge clk);
      checkOutput("rx_no_extra_store", store_count - base, 1);

      // Reset mid-transmission of A5 while DOUT holds 3C
      din = 8'hA5;
      drl = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("pre_reset_tx_low", int'(tx), 0);
      #2;
      init = 1'b1;
      drl  = 1'b0;
      #1;
      checkOutput("abort_tx", int'(tx), 1);
      checkOutput("abort_load", int'(load), 0);
      checkOutput("abort_store", int'(store), 0);
      checkOutput("abort_dout", int'(dout), 0);
      repeat (3) @(negedge clk);
      init = 1'b0;
      load_hi = 0;
      tx_low_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (load) load_hi++;
         if (!tx) tx_low_seen++;
      end
      checkOutput("post_reset_no_load", load_hi, 0);
      checkOutput("post_reset_tx_idle", tx_low_seen, 0);

      // TX single byte waveform, DRL pulsed for one cycle
      @(negedge clk);
      din = 8'h06;
      drl = 1'b1;
      @(negedge clk);
      drl = 1'b0;
      checkOutput("tx_load_pulse", int'(load), 1);
      din = 8'hFF;
      load_hi = 0;
      for (int k = 0; k < 80; k++) begin
         wave[k] = tx;
         if (k > 0 && load) load_hi++;
         @(negedge clk);
      end
      frame = {1'b1, 8'h06, 1'b0};
      for (int b = 0; b < 10; b++) begin
         checkOutput($sformatf("tx_wave_bit%0d", b), int'(wave[b*8 +: 8]), frame[b] ? 255 : 0);
      end
      checkOutput("tx_load_single", load_hi, 0);
      checkOutput("tx_idle_after", int'(tx), 1);

      // TX back-to-back with DRL held
      tx_mon_on = 1'b1;
      tx_send = '{8'h14, 8'h07};
      applyStimulus();
      waitDrain();

      // RX errors: a valid byte first so DOUT has something to hold
      base = store_count;
      rx_exp_q.push_back(8'h5A);
      driveRxFrame(8'h5A, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checkOutput("rx_valid_before_err", store_count - base, 1);

      base = store_count;
      rx_drive = 1'b0;
      repeat (2) @(negedge clk);
      rx_drive = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      checkOutput("rx_glitch_no_store", store_count - base, 0);

      driveRxFrame(8'h55, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      rx_drive = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checkOutput("rx_framing_no_store", store_count - base, 0);
      checkOutput("rx_framing_dout_held", int'(dout), 8'h5A);

      rx_exp_q.push_back(8'hAA);
      driveRxFrame(8'hAA, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checkOutput("rx_after_break", store_count - base, 1);

      // Loopback
      base = store_count;
      loopback = 1'b1;
      repeat (2) @(negedge clk);
      tx_send = '{8'h00, 8'hFF, 8'h08};
      applyStimulus();
      waitDrain();
      checkOutput("loopback_stores", store_count - base, 3);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule

// File: doc/rs232_uart.md
Name: rs232_uart

Overview:
Full-duplex 8N1 UART core with two independent halves: a byte transmitter (serialises DIN onto TX) and a byte receiver (deserialises RX into DOUT). It sits under the frame-level interface, which pushes bytes to the host via the DRL/LOAD handshake and collects host bytes on the one-cycle STORE strobe. Fixed bit timing is derived from the system clock by a parameterised divider.

Parameters:
CLKS_PER_BIT, 434, system clock cycles per serial bit (50 MHz / 115200); minimum 4
DATA_BITS, 8, data bits per character (fixed at 8; DIN/DOUT width)

Ports:
CLK  input  1  system clock, all logic on rising edge
INIT  input  1  asynchronous active-high reset
DRL  input  1  data-ready level; transmitter sends DIN whenever idle and DRL=1
DIN  input  8  byte to transmit, sampled on the load edge
LOAD  output  1  one-cycle pulse: DIN has been captured, next byte may be presented
TX  output  1  serial output, idle high
RX  input  1  serial input, asynchronous to CLK
STORE  output  1  one-cycle pulse: new byte valid on DOUT
DOUT  output  8  last received byte, held until next STORE

Behaviour:
- Reset (INIT=1, async): TX=1, LOAD=0, STORE=0, DOUT=8'h00, both FSMs in IDLE, all counters zero. Reset mid-character aborts it; TX goes high immediately.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit exactly CLKS_PER_BIT cycles.
- Transmitter FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE.
  - IDLE with DRL=1: on that edge latch DIN into shift register, assert LOAD for exactly one cycle, drive TX=0 (start bit begins the cycle after the edge).
  - DIN changes after LOAD do not affect the byte in flight.
  - After STOP's last cycle return to IDLE; if DRL still 1, next byte loads on the following edge (back-to-back characters, gap of at most 1 clock).
  - DRL=0 in IDLE: TX stays 1, LOAD stays 0. Dropping DRL mid-character does not abort it.
- Receiver FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE.
  - RX passes through a 2-flop synchroniser before use.
  - IDLE: falling edge (synchronised RX=0) enters START; sample at CLKS_PER_BIT/2. If RX=1 there, treat as glitch and return to IDLE.
  - DATA: sample each bit at its centre (every CLKS_PER_BIT cycles after the start-centre); shift in LSB first.
  - STOP: sample at centre. If 1: DOUT <= assembled byte and STORE=1 for one cycle on the same edge; return to IDLE. If 0 (framing error): no STORE, DOUT unchanged, stay in a BREAK wait until RX=1, then IDLE.
  - Receiver re-arms from the stop-bit centre, so a following start bit is detected with no extra idle time.
- Transmitter and receiver share only CLK/INIT; a loopback (TX tied to RX) must work.

Optional Feature:
RS232_PARITY_EN: when defined, both halves insert an even parity bit between bit 7 and stop (11-bit frame). Receiver checks it; on mismatch it suppresses STORE and leaves DOUT unchanged, but still requires and consumes the stop bit. When undefined, behaviour is plain 8N1 as above.

Test Plan:
- Reset: hold INIT=1 mid-transmission of 8'hA5 -> TX=1, LOAD=0, STORE=0, DOUT=8'h00 immediately; after release TX stays 1 with DRL=0.
- TX single byte (CLKS_PER_BIT=8): DIN=8'h06, DRL pulsed 1 cycle -> LOAD 1-cycle pulse; TX waveform 0,0,1,1,0,0,0,0,0,1, each bit 8 clocks; total 80 clocks.
- TX back-to-back: DRL held 1, DIN updated to 8'h07 on LOAD after 8'h14 -> two contiguous frames, second LOAD exactly 80/81 clocks after first, bytes 8'h14 then 8'h07.
- RX byte: drive 8'h3C frame on RX at 8 clocks/bit -> single STORE pulse at stop-bit centre, DOUT=8'h3C; no further STORE while RX idle.
- RX errors: 2-clock low glitch on RX -> no STORE; frame 8'h55 with stop bit 0 -> no STORE, DOUT keeps previous value; next valid 8'hAA received correctly after RX returns high.
- Loopback: TX->RX, DRL high, send 8'h00, 8'hFF, 8'h08 -> three STORE pulses with DOUT matching in order.
